rice_core_trap_ctrl: RTL and testbench
======================================

Name: rice_core_trap_ctrl

Overview:
Machine-mode trap sequencer for the rice core. It sits on the env side of the core environment interface.
- Consumes exception/mret events retired by the EX stage.
- Owns the trap CSRs (mstatus MIE/MPIE/MPP, mtvec, mepc, mcause, mtval) and the current privilege level.
- Drives trap_pc/return_pc and issues a handshaked pipeline redirect for each trap entry or return.

Parameters:
XLEN, 32, data/PC width (32 or 64)
MTVEC_RESET, 0, reset value of mtvec (bits [1:0] must be 0)
U_MODE, 1, 1 = U-mode implemented; 0 = M-only (MPP and privilege fixed at M)

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous reset, active-high
i_valid  input  1  EX-stage instruction retiring this cycle
i_exception  input  1  retiring instruction raised an exception (qualified by i_valid)
i_cause  input  4  exception code (0 inst-misaligned, 1 inst-fault, 2 illegal, 3 ebreak, 4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault, 8 ecall-U, 11 ecall-M)
i_mret  input  1  retiring instruction is mret (qualified by i_valid)
i_pc  input  XLEN  PC of retiring instruction
i_inst  input  32  encoding of retiring instruction
i_tval  input  XLEN  faulting address for misaligned/fault causes
i_csr_we  input  1  CSR write strobe
i_csr_addr  input  12  CSR address
i_csr_wdata  input  XLEN  CSR write data
o_csr_rdata  output  XLEN  combinational read of i_csr_addr (0 for unmapped)
o_privilege_level  output  2  current privilege (0 U, 3 M)
o_trap_pc  output  XLEN  mtvec base
o_return_pc  output  XLEN  mepc
o_redirect_valid  output  1  redirect request to fetch/pipeline flush
o_redirect_pc  output  XLEN  redirect target
i_redirect_ready  input  1  redirect accepted
o_busy  output  1  controller not IDLE; EX must stall retirement

Behaviour:
- Reset values (async on i_rst): privilege=M; mstatus MIE=0, MPIE=0, MPP=M; mtvec=MTVEC_RESET; mepc/mcause/mtval=0; state=IDLE; o_redirect_valid=0; o_busy=0.
- FSM states: IDLE, TRAP_REDIRECT, RET_REDIRECT.
- IDLE, i_valid&i_exception (wins over i_mret and CSR write), next edge:
  - mepc={i_pc[XLEN-1:2],2'b00}; mcause=zero-extended i_cause.
  - mtval=i_inst zero-extended for cause 2; i_pc for cause 3; i_tval for causes 0,1,4-7; 0 for 8/11.
  - MPIE=MIE, MIE=0, MPP=privilege, privilege=M.
  - Go to TRAP_REDIRECT.
- IDLE, i_valid&i_mret&!i_exception, next edge:
  - privilege=MPP; MIE=MPIE; MPIE=1; MPP=U (M if U_MODE=0).
  - Go to RET_REDIRECT. Redirect target = mepc sampled before this edge.
- TRAP_REDIRECT/RET_REDIRECT:
  - o_redirect_valid=1; o_redirect_pc=mtvec (trap) or mepc (return); payload stable while !i_redirect_ready.
  - On valid&ready return to IDLE; o_redirect_valid low the following cycle.
  - Minimum latency: event edge -> redirect_valid next cycle; ready same cycle -> IDLE after 1 cycle.
- o_busy=1 in any non-IDLE state. i_valid, i_exception, i_mret and i_csr_we are ignored while busy.
- CSR writes (IDLE, no simultaneous exception/mret):
  - mstatus: only MIE[3], MPIE[7], MPP[12:11] writable. MPP writes of 1 or 2 map to M; 0 maps to M when U_MODE=0.
  - mtvec/mepc: bits[1:0] forced 0 (direct mode only).
  - mcause/mtval: full width. Other addresses dropped.
- CSR write plus mret in the same cycle: mret wins, write dropped.
- o_csr_rdata reflects registered state; a write is visible on the cycle after.
- o_trap_pc=mtvec and o_return_pc=mepc continuously.
- Reset mid-redirect: state and redirect_valid clear immediately (async); no redirect completes.

Decomposition:
- rice_core_pkg additions:
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343).
  - rice_core_exception_code enum.
  - mstatus packed struct.
  - trap FSM state enum.
- Privilege type reuses rice_core_privilege_level.
- One sub-module: rice_core_trap_csr, holding the CSR register file, WARL masking and read mux. The FSM and redirect logic stay in the top.

Test Plan:
- Illegal inst: U-mode, MIE=1, mtvec=0x100, i_pc=0x2002, i_inst=0xFFFFFFFF, cause 2 -> mepc=0x2000, mcause=2, mtval=0xFFFFFFFF, MPIE=1, MIE=0, MPP=U, priv=M, redirect_pc=0x100.
- Backpressure: hold i_redirect_ready=0 for 5 cycles -> redirect_valid/pc stable, o_busy=1, injected ecall ignored; ready=1 -> IDLE next cycle.
- mret: mepc=0x4000, MPP=U, MPIE=1 -> redirect_pc=0x4000, priv=U, MIE=1, MPIE=1, MPP=U.
- Simultaneous exception (cause 11), mret and CSR write to mtvec=0x200 -> trap taken with old mtvec target, mtvec unchanged.
- WARL: write mtvec=0x203 -> reads 0x200; mstatus write MPP=2 -> reads MPP=3; U_MODE=0 and MPP=0 written -> reads 3.
- Reset asserted during TRAP_REDIRECT -> redirect_valid=0 immediately, priv=M, mtvec=MTVEC_RESET, o_busy=0.

Source files
------------

// File: rtl/rice_core_pkg.sv
// Shared rice core types: privilege levels, trap CSR addresses, exception codes,
// the mstatus trap fields and the trap sequencer state encoding.
package rice_core_pkg;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_M = 2'b11
   } rice_core_privilege_level;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   typedef enum logic [3:0] {
      EXC_INST_MISALIGNED  = 4'd0,
      EXC_INST_FAULT       = 4'd1,
      EXC_ILLEGAL          = 4'd2,
      EXC_EBREAK           = 4'd3,
      EXC_LOAD_MISALIGNED  = 4'd4,
      EXC_LOAD_FAULT       = 4'd5,
      EXC_STORE_MISALIGNED = 4'd6,
      EXC_STORE_FAULT      = 4'd7,
      EXC_ECALL_U          = 4'd8,
      EXC_ECALL_M          = 4'd11
   } rice_core_exception_code;

   typedef struct packed {
      rice_core_privilege_level mpp;
      logic                     mpie;
      logic                     mie;
   } rice_core_mstatus;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      TRAP_REDIRECT = 2'd1,
      RET_REDIRECT  = 2'd2
   } rice_core_trap_state;

endpackage

// File: rtl/rice_core_trap_ctrl_if.sv
// Core environment port bundle between the EX stage / fetch (master) and the
// trap sequencer (slave).
interface rice_core_trap_ctrl_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic            i_exception;
   logic [3:0]      i_cause;
   logic            i_mret;
   logic [XLEN-1:0] i_pc;
   logic [31:0]     i_inst;
   logic [XLEN-1:0] i_tval;
   logic            i_csr_we;
   logic [11:0]     i_csr_addr;
   logic [XLEN-1:0] i_csr_wdata;
   logic [XLEN-1:0] o_csr_rdata;
   logic [1:0]      o_privilege_level;
   logic [XLEN-1:0] o_trap_pc;
   logic [XLEN-1:0] o_return_pc;
   logic            o_redirect_valid;
   logic [XLEN-1:0] o_redirect_pc;
   logic            i_redirect_ready;
   logic            o_busy;

   modport master (
      output i_valid, i_exception, i_cause, i_mret, i_pc, i_inst, i_tval,
      output i_csr_we, i_csr_addr, i_csr_wdata, i_redirect_ready,
      input  o_csr_rdata, o_privilege_level, o_trap_pc, o_return_pc,
      input  o_redirect_valid, o_redirect_pc, o_busy
   );

   modport slave (
      input  i_valid, i_exception, i_cause, i_mret, i_pc, i_inst, i_tval,
      input  i_csr_we, i_csr_addr, i_csr_wdata, i_redirect_ready,
      output o_csr_rdata, o_privilege_level, o_trap_pc, o_return_pc,
      output o_redirect_valid, o_redirect_pc, o_busy
   );
endinterface

// File: rtl/rice_core_trap_csr.sv
// Trap CSR register file: mstatus trap fields, mtvec, mepc, mcause, mtval and
// current privilege, with WARL write masking and a combinational read mux.
module rice_core_trap_csr
   import rice_core_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter int              U_MODE      = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trap_en,
   input  logic                     ret_en,
   input  logic                     csr_we,
   input  logic [11:0]              csr_addr,
   input  logic [XLEN-1:0]          csr_wdata,
   input  logic [3:0]               cause,
   input  logic [XLEN-1:0]          pc,
   input  logic [31:0]              inst,
   input  logic [XLEN-1:0]          tval,
   output logic [XLEN-1:0]          csr_rdata,
   output rice_core_privilege_level priv,
   output logic [XLEN-1:0]          mtvec,
   output logic [XLEN-1:0]          mepc
);

   rice_core_mstatus mstatus;
   logic [XLEN-1:0]  mcause;
   logic [XLEN-1:0]  mtval;

   // Reserved MPP encodings collapse to M; U collapses to M on an M-only core.
   function automatic rice_core_privilege_level warl_mpp(input logic [1:0] v);
      if (v == 2'b00 && U_MODE != 0) return PRIV_U;
      return PRIV_M;
   endfunction

   function automatic logic [XLEN-1:0] trap_tval(input logic [3:0] c);
      case (c)
         EXC_ILLEGAL: return XLEN'(inst);
         EXC_EBREAK:  return pc;
         EXC_INST_MISALIGNED, EXC_INST_FAULT, EXC_LOAD_MISALIGNED,
         EXC_LOAD_FAULT, EXC_STORE_MISALIGNED, EXC_STORE_FAULT: return tval;
         default:     return '0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         priv         <= PRIV_M;
         mstatus.mie  <= 1'b0;
         mstatus.mpie <= 1'b0;
         mstatus.mpp  <= PRIV_M;
         mtvec        <= {MTVEC_RESET[XLEN-1:2], 2'b00};
         mepc         <= '0;
         mcause       <= '0;
         mtval        <= '0;
      end else if (trap_en) begin
         mepc         <= {pc[XLEN-1:2], 2'b00};
         mcause       <= XLEN'(cause);
         mtval        <= trap_tval(cause);
         mstatus.mpie <= mstatus.mie;
         mstatus.mie  <= 1'b0;
         mstatus.mpp  <= priv;
         priv         <= PRIV_M;
      end else if (ret_en) begin
         priv         <= mstatus.mpp;
         mstatus.mie  <= mstatus.mpie;
         mstatus.mpie <= 1'b1;
         mstatus.mpp  <= (U_MODE != 0) ? PRIV_U : PRIV_M;
      end else if (csr_we) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mstatus.mie  <= csr_wdata[3];
               mstatus.mpie <= csr_wdata[7];
               mstatus.mpp  <= warl_mpp(csr_wdata[12:11]);
            end
            CSR_MTVEC:  mtvec  <= {csr_wdata[XLEN-1:2], 2'b00};
            CSR_MEPC:   mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
            CSR_MCAUSE: mcause <= csr_wdata;
            CSR_MTVAL:  mtval  <= csr_wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_MSTATUS: csr_rdata = XLEN'({mstatus.mpp, 3'b000, mstatus.mpie, 3'b000, mstatus.mie, 3'b000});
         CSR_MTVEC:   csr_rdata = mtvec;
         CSR_MEPC:    csr_rdata = mepc;
         CSR_MCAUSE:  csr_rdata = mcause;
         CSR_MTVAL:   csr_rdata = mtval;
         default:     csr_rdata = '0;
      endcase
   end

endmodule

// File: rtl/rice_core_trap_ctrl.sv
// Machine-mode trap sequencer: accepts exception/mret retirements from EX and
// issues one handshaked pipeline redirect per trap entry or return.
module rice_core_trap_ctrl
   import rice_core_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter int              U_MODE      = 1
) (
   input logic                  i_clk,
   input logic                  i_rst,
   rice_core_trap_ctrl_if.slave bus
);

   rice_core_trap_state      state_q;
   logic                     redirect_valid_q;
   logic                     busy_q;
   logic [XLEN-1:0]          redirect_pc_q;
   rice_core_privilege_level priv;
   logic [XLEN-1:0]          mtvec;
   logic [XLEN-1:0]          mepc;
   logic                     idle;
   logic                     trap_en;
   logic                     ret_en;
   logic                     csr_we;

   // Exception beats mret, and either one drops a same-cycle CSR write.
   assign idle    = (state_q == IDLE);
   assign trap_en = idle & bus.i_valid & bus.i_exception;
   assign ret_en  = idle & bus.i_valid & bus.i_mret & ~bus.i_exception;
   assign csr_we  = idle & bus.i_csr_we & ~(bus.i_valid & (bus.i_exception | bus.i_mret));

   rice_core_trap_csr #(
      .XLEN        (XLEN),
      .MTVEC_RESET (MTVEC_RESET),
      .U_MODE      (U_MODE)
   ) u_csr (
      .clk       (i_clk),
      .rst       (i_rst),
      .trap_en   (trap_en),
      .ret_en    (ret_en),
      .csr_we    (csr_we),
      .csr_addr  (bus.i_csr_addr),
      .csr_wdata (bus.i_csr_wdata),
      .cause     (bus.i_cause),
      .pc        (bus.i_pc),
      .inst      (bus.i_inst),
      .tval      (bus.i_tval),
      .csr_rdata (bus.o_csr_rdata),
      .priv      (priv),
      .mtvec     (mtvec),
      .mepc      (mepc)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q          <= IDLE;
         redirect_valid_q <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trap_en) begin
                  state_q          <= TRAP_REDIRECT;
                  redirect_valid_q <= 1'b1;
                  busy_q           <= 1'b1;
               end else if (ret_en) begin
                  state_q          <= RET_REDIRECT;
                  redirect_valid_q <= 1'b1;
                  busy_q           <= 1'b1;
               end
            end
            TRAP_REDIRECT, RET_REDIRECT: begin
               if (bus.i_redirect_ready) begin
                  state_q          <= IDLE;
                  redirect_valid_q <= 1'b0;
                  busy_q           <= 1'b0;
               end
            end
            default: begin
               state_q          <= IDLE;
               redirect_valid_q <= 1'b0;
               busy_q           <= 1'b0;
            end
         endcase
      end
   end

   // Target is captured at the event edge so it holds steady under backpressure.
   always_ff @(posedge i_clk) begin
      if (trap_en)     redirect_pc_q <= mtvec;
      else if (ret_en) redirect_pc_q <= mepc;
   end

   assign bus.o_privilege_level = priv;
   assign bus.o_trap_pc         = mtvec;
   assign bus.o_return_pc       = mepc;
   assign bus.o_redirect_valid  = redirect_valid_q;
   assign bus.o_redirect_pc     = redirect_pc_q;
   assign bus.o_busy            = busy_q;

endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
// Directed bench for rice_core_trap_ctrl: redirect targets go through a
// scoreboard queue, CSR and privilege state is checked directly.
module tb_rice_core_trap_ctrl;
   import rice_core_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rice_core_trap_ctrl_if #(.XLEN(32)) bus0 ();
   rice_core_trap_ctrl_if #(.XLEN(32)) bus1 ();

   rice_core_trap_ctrl #(.XLEN(32), .MTVEC_RESET(32'h0), .U_MODE(1)) dut0 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus0)
   );

   rice_core_trap_ctrl #(.XLEN(32), .MTVEC_RESET(32'h80), .U_MODE(0)) dut1 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus1)
   );

   int          nchecks = 0;
   int          nerrors = 0;
   logic [31:0] exp_q[$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: every accepted redirect must match the oldest queued target.
   always @(negedge clk) begin
      if (!rst && bus0.o_redirect_valid && bus0.i_redirect_ready) begin
         if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL redirect_unexpected: got pc %0h, expected no redirect", bus0.o_redirect_pc);
         end else begin
            check("redirect_pc", bus0.o_redirect_pc, exp_q.pop_front());
         end
      end
   end

   task automatic idle0();
      bus0.i_valid     = 1'b0;
      bus0.i_exception = 1'b0;
      bus0.i_cause     = 4'd0;
      bus0.i_mret      = 1'b0;
      bus0.i_pc        = '0;
      bus0.i_inst      = '0;
      bus0.i_tval      = '0;
      bus0.i_csr_we    = 1'b0;
      bus0.i_csr_addr  = '0;
      bus0.i_csr_wdata = '0;
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      bus0.i_csr_we    = 1'b1;
      bus0.i_csr_addr  = a;
      bus0.i_csr_wdata = d;
      align();
      idle0();
   endtask

   task automatic retire(input logic exc, input logic [3:0] cause, input logic mret,
                         input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] tval);
      bus0.i_valid     = 1'b1;
      bus0.i_exception = exc;
      bus0.i_cause     = cause;
      bus0.i_mret      = mret;
      bus0.i_pc        = pc;
      bus0.i_inst      = inst;
      bus0.i_tval      = tval;
      align();
      idle0();
   endtask

   task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
      bus0.i_csr_addr = a;
      #1;
      check(name, bus0.o_csr_rdata, exp);
      bus0.i_csr_addr = '0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus0.o_busy && n < 20) begin
         align();
         n++;
      end
      check(name, 32'(bus0.o_busy), 32'h0);
   endtask

   initial begin
      idle0();
      bus0.i_redirect_ready = 1'b0;
      bus1.i_valid = 1'b0; bus1.i_exception = 1'b0; bus1.i_cause = 4'd0; bus1.i_mret = 1'b0;
      bus1.i_pc = '0; bus1.i_inst = '0; bus1.i_tval = '0; bus1.i_csr_we = 1'b0;
      bus1.i_csr_addr = '0; bus1.i_csr_wdata = '0; bus1.i_redirect_ready = 1'b1;

      #2 rst = 1'b1;
      repeat (2) align();
      check("reset_priv", 32'(bus0.o_privilege_level), 32'h3);
      check("reset_busy", 32'(bus0.o_busy), 32'h0);
      check("reset_redirect_valid", 32'(bus0.o_redirect_valid), 32'h0);
      rst = 1'b0;
      align();
      chk_csr("reset_mstatus", CSR_MSTATUS, 32'h1800);
      chk_csr("reset_mtvec", CSR_MTVEC, 32'h0);
      chk_csr("reset_mepc", CSR_MEPC, 32'h0);
      align();

      // Drop to U-mode with MIE=1 via mret.
      bus0.i_redirect_ready = 1'b1;
      csr_wr(CSR_MSTATUS, 32'h80);
      csr_wr(CSR_MEPC, 32'h1000);
      exp_q.push_back(32'h1000);
      retire(1'b0, 4'd0, 1'b1, 32'h0C00, 32'h0, 32'h0);
      wait_idle("setup_mret_idle");
      check("setup_priv_u", 32'(bus0.o_privilege_level), 32'h0);
      csr_wr(CSR_MTVEC, 32'h100);

      // Illegal instruction from U-mode.
      exp_q.push_back(32'h100);
      retire(1'b1, 4'd2, 1'b0, 32'h2002, 32'hFFFFFFFF, 32'h0);
      wait_idle("illegal_idle");
      check("illegal_priv", 32'(bus0.o_privilege_level), 32'h3);
      chk_csr("illegal_mepc", CSR_MEPC, 32'h2000);
      chk_csr("illegal_mcause", CSR_MCAUSE, 32'h2);
      chk_csr("illegal_mtval", CSR_MTVAL, 32'hFFFFFFFF);
      chk_csr("illegal_mstatus", CSR_MSTATUS, 32'h80);
      align();

      // Backpressure: ebreak, ready held low, ecall injected while busy.
      bus0.i_redirect_ready = 1'b0;
      retire(1'b1, 4'd3, 1'b0, 32'h3000, 32'h00100073, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(bus0.o_redirect_valid), 32'h1);
         check("bp_pc", bus0.o_redirect_pc, 32'h100);
         check("bp_busy", 32'(bus0.o_busy), 32'h1);
         if (i == 1) begin
            bus0.i_valid = 1'b1; bus0.i_exception = 1'b1; bus0.i_cause = 4'd8;
            bus0.i_pc = 32'h5000;
         end else begin
            idle0();
         end
      end
      align();
      exp_q.push_back(32'h100);
      bus0.i_redirect_ready = 1'b1;
      align();
      check("bp_release_valid", 32'(bus0.o_redirect_valid), 32'h0);
      check("bp_release_busy", 32'(bus0.o_busy), 32'h0);
      chk_csr("bp_mepc", CSR_MEPC, 32'h3000);
      chk_csr("bp_mcause", CSR_MCAUSE, 32'h3);
      chk_csr("bp_mtval", CSR_MTVAL, 32'h3000);
      chk_csr("bp_mstatus", CSR_MSTATUS, 32'h1800);
      align();

      // mret back to U-mode.
      csr_wr(CSR_MEPC, 32'h4000);
      csr_wr(CSR_MSTATUS, 32'h80);
      exp_q.push_back(32'h4000);
      retire(1'b0, 4'd0, 1'b1, 32'h4010, 32'h30200073, 32'h0);
      wait_idle("mret_idle");
      check("mret_priv", 32'(bus0.o_privilege_level), 32'h0);
      chk_csr("mret_mstatus", CSR_MSTATUS, 32'h88);
      align();

      // Exception + mret + mtvec write in one cycle: trap wins with old mtvec.
      exp_q.push_back(32'h100);
      bus0.i_csr_we = 1'b1; bus0.i_csr_addr = CSR_MTVEC; bus0.i_csr_wdata = 32'h200;
      retire(1'b1, 4'd11, 1'b1, 32'h5004, 32'h00000073, 32'hDEAD);
      wait_idle("simul_idle");
      check("simul_priv", 32'(bus0.o_privilege_level), 32'h3);
      chk_csr("simul_mtvec", CSR_MTVEC, 32'h100);
      chk_csr("simul_mcause", CSR_MCAUSE, 32'hB);
      chk_csr("simul_mtval", CSR_MTVAL, 32'h0);
      chk_csr("simul_mepc", CSR_MEPC, 32'h5004);
      chk_csr("simul_mstatus", CSR_MSTATUS, 32'h80);
      align();

      // WARL masking.
      csr_wr(CSR_MTVEC, 32'h203);
      chk_csr("warl_mtvec", CSR_MTVEC, 32'h200);
      align();
      csr_wr(CSR_MSTATUS, 32'h1000);
      chk_csr("warl_mpp2", CSR_MSTATUS, 32'h1800);
      align();
      csr_wr(CSR_MSTATUS, 32'hFFFFFFFF);
      chk_csr("warl_mstatus_ones", CSR_MSTATUS, 32'h1888);
      align();
      csr_wr(12'h123, 32'h55AA);
      chk_csr("unmapped_read", 12'h123, 32'h0);
      align();

      bus1.i_csr_we = 1'b1; bus1.i_csr_addr = CSR_MSTATUS; bus1.i_csr_wdata = 32'h0;
      align();
      bus1.i_csr_we = 1'b0;
      #1;
      check("monly_mpp", bus1.o_csr_rdata, 32'h1800);
      bus1.i_csr_addr = CSR_MTVEC;
      #1;
      check("monly_mtvec_reset", bus1.o_csr_rdata, 32'h80);
      check("monly_priv", 32'(bus1.o_privilege_level), 32'h3);
      align();

      // Reset during TRAP_REDIRECT.
      bus0.i_redirect_ready = 1'b0;
      retire(1'b1, 4'd5, 1'b0, 32'h6000, 32'h0, 32'h6001);
      @(negedge clk);
      check("rst_mid_valid_before", 32'(bus0.o_redirect_valid), 32'h1);
      #1 rst = 1'b1;
      bus0.i_csr_addr = CSR_MTVEC;
      #1;
      check("rst_mid_valid", 32'(bus0.o_redirect_valid), 32'h0);
      check("rst_mid_busy", 32'(bus0.o_busy), 32'h0);
      check("rst_mid_priv", 32'(bus0.o_privilege_level), 32'h3);
      check("rst_mid_mtvec", bus0.o_csr_rdata, 32'h0);
      align();
      rst = 1'b0;
      idle0();
      bus0.i_redirect_ready = 1'b1;
      repeat (2) align();
      check("rst_mid_no_redirect", 32'(bus0.o_redirect_valid), 32'h0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
